// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the clock display path:
//                transmitter state encoding, digit count, segment byte
//                width, select settle time and the blank BCD code.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Transmitter frame states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_DONE   = 3'd4
    } tx_state_t;

    localparam int NUM_DIGITS_DEFAULT = 6;
    // Bits per shifted byte: decimal point plus seven segments
    localparam int SEG_BITS           = 8;
    // Cycles spent on each select: one for the mux register, one for decode
    localparam int SELECT_WAIT        = 2;
    // BCD code the digit mux uses to blank a digit
    localparam logic [3:0] BLANK_BCD  = 4'hA;

endpackage
`default_nettype wire

// File: rtl/serial_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tick_gen
//  Description : Divides i_clk by CLK_DIV and raises o_tick for one cycle on
//                the last cycle of every phase. i_clear restarts the count so
//                each new phase begins with a full CLK_DIV cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    // Keep at least one counter bit so CLK_DIV=1 still elaborates
    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    assign o_tick = i_en && !i_clear && (cnt_q == c_last);

    // Next count: clear wins, otherwise count up and reload at the phase end
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/segment_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : segment_shift_tx
//  Description : Walks the digit select through 0..NUM_DIGITS-1, captures
//                each decoded segment pattern and shifts it MSB-first into
//                the external 7-segment shift-register chain, then pulses the
//                latch. Define SEGMENT_TX_DP_EN to add the i_dp port and send
//                a per-digit decimal point in bit 7; otherwise bit 7 is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module segment_shift_tx
    import display_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [6:0] i_led_out,
`ifdef SEGMENT_TX_DP_EN
    input  logic [5:0] i_dp,
`endif
    output logic [2:0] o_segment_select,
    output logic       o_serial_data,
    output logic       o_serial_clk,
    output logic       o_serial_latch,
    output logic       o_busy,
    output logic       o_done
);

    localparam int c_sel_w = (SELECT_WAIT > 1) ? $clog2(SELECT_WAIT) : 1;
    localparam int c_bit_w = $clog2(SEG_BITS);
    localparam logic [c_sel_w-1:0] c_sel_last   = c_sel_w'(SELECT_WAIT - 1);
    localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(SEG_BITS - 1);
    localparam logic [2:0]         c_last_digit = 3'(NUM_DIGITS - 1);

    tx_state_t            state_q,   state_d;
    logic [2:0]           digit_q,   digit_d;
    logic [c_sel_w-1:0]   sel_cnt_q, sel_cnt_d;
    logic [c_bit_w-1:0]   bit_q,     bit_d;
    logic [SEG_BITS-1:0]  shift_q,   shift_d;
    logic                 sclk_q,    sclk_d;
    logic                 data_q,    data_d;
    logic                 latch_q,   latch_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic                 w_tick;
    logic                 w_div_active;
    logic                 w_dp_bit;

`ifdef SEGMENT_TX_DP_EN
    assign w_dp_bit = i_dp[digit_q];
`else
    assign w_dp_bit = 1'b0;
`endif

    // The divider only runs while a serial phase is being timed
    assign w_div_active = (state_q == ST_SHIFT) || (state_q == ST_LATCH);

    serial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (!w_div_active),
        .i_en      (w_div_active),
        .o_tick    (w_tick)
    );

    // Next-state and next-output logic; outputs derive from the next state
    // so every port is driven straight from a flop
    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        sel_cnt_d = sel_cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        data_d    = data_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                data_d = 1'b0;
                if (i_start) begin
                    state_d   = ST_SELECT;
                    digit_d   = 3'd0;
                    sel_cnt_d = '0;
                end
            end
            ST_SELECT: begin
                if (sel_cnt_q == c_sel_last) begin
                    // Decoded segments are settled now: capture and present bit 7
                    sel_cnt_d = '0;
                    shift_d   = {w_dp_bit, i_led_out};
                    data_d    = w_dp_bit;
                    sclk_d    = 1'b0;
                    bit_d     = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    sel_cnt_d = sel_cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == c_bit_last) begin
                            bit_d = '0;
                            if (digit_q < c_last_digit) begin
                                digit_d = digit_q + 3'd1;
                                state_d = ST_SELECT;
                            end else begin
                                data_d  = 1'b0;
                                state_d = ST_LATCH;
                            end
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shift_d = {shift_q[SEG_BITS-2:0], 1'b0};
                            data_d  = shift_q[SEG_BITS-2];
                        end
                    end
                end
            end
            ST_LATCH: begin
                sclk_d = 1'b0;
                data_d = 1'b0;
                if (w_tick) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        latch_d = (state_d == ST_LATCH);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            digit_q   <= 3'd0;
            sel_cnt_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            data_q    <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            sel_cnt_q <= sel_cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            data_q    <= data_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_segment_select = digit_q;
    assign o_serial_data    = data_q;
    assign o_serial_clk     = sclk_q;
    assign o_serial_latch   = latch_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_segment_shift_tx
//  Description : Self-checking bench for segment_shift_tx. Two instances
//                (CLK_DIV=2 and CLK_DIV=1) are driven by a registered digit
//                mux model returning random per-digit patterns; received
//                serial bytes and frame timing are compared with values
//                computed from the frame rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_shift_tx;

`ifdef SEGMENT_TX_DP_EN
    localparam bit c_dp_en = 1'b1;
`else
    localparam bit c_dp_en = 1'b0;
`endif
    localparam int c_digits = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start2;
    logic [5:0] dp;
    logic [6:0] pat [0:7];
    logic [2:0] mux1_q = '0;
    logic [2:0] mux2_q = '0;
    logic [6:0] led1, led2;

    logic [2:0] sel1, sel2;
    logic       sd1, sd2, sc1, sc2, sl1, sl2, bz1, bz2, dn1, dn2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Digit mux register: the decoder output follows select one edge later
    always @(posedge clk) begin
        mux1_q <= sel1;
        mux2_q <= sel2;
    end
    assign led1 = pat[mux1_q];
    assign led2 = pat[mux2_q];

    segment_shift_tx #(.CLK_DIV(2), .NUM_DIGITS(c_digits)) u_dut1 (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_start          (start1),
        .i_led_out        (led1),
`ifdef SEGMENT_TX_DP_EN
        .i_dp             (dp),
`endif
        .o_segment_select (sel1),
        .o_serial_data    (sd1),
        .o_serial_clk     (sc1),
        .o_serial_latch   (sl1),
        .o_busy           (bz1),
        .o_done           (dn1)
    );

    segment_shift_tx #(.CLK_DIV(1), .NUM_DIGITS(c_digits)) u_dut2 (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_start          (start2),
        .i_led_out        (led2),
`ifdef SEGMENT_TX_DP_EN
        .i_dp             (dp),
`endif
        .o_segment_select (sel2),
        .o_serial_data    (sd2),
        .o_serial_clk     (sc2),
        .o_serial_latch   (sl2),
        .o_busy           (bz2),
        .o_done           (dn2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic get(input int unit, output logic sc, output logic sd, output logic sl,
                       output logic bz, output logic dn, output logic [2:0] sel);
        if (unit == 1) begin
            sc = sc1; sd = sd1; sl = sl1; bz = bz1; dn = dn1; sel = sel1;
        end else begin
            sc = sc2; sd = sd2; sl = sl2; bz = bz2; dn = dn2; sel = sel2;
        end
    endtask

    task automatic drive_start(input int unit, input logic v);
        if (unit == 1) start1 = v;
        else           start2 = v;
    endtask

    // One full frame from a start request in the current cycle (cycle 0).
    // Ends in cycle F+1, where a new frame may be requested immediately.
    task automatic run_frame(input int unit, input int div, input bit poke);
        int         f;
        logic       got [$];
        logic [7:0] exp_byte, obs_byte;
        logic       sc, sd, sl, bz, dn, prev_sc;
        logic [2:0] sel;
        int first_rise, latch_first, latch_n, done_cyc, done_n;
        int hi_run, bad_hi, latch_bad, busy_gap;

        f = c_digits * (2 + 16 * div) + div + 1;
        for (int i = 0; i < 8; i++) pat[i] = 7'($urandom);
        dp = 6'($urandom);
        first_rise = -1; latch_first = -1; latch_n = 0; done_cyc = -1; done_n = 0;
        hi_run = 0; bad_hi = 0; latch_bad = 0; busy_gap = 0; prev_sc = 1'b0;

        get(unit, sc, sd, sl, bz, dn, sel);
        chk("idle_busy_before_start", 32'(bz), 32'd0);
        drive_start(unit, 1'b1);

        for (int k = 1; k <= f + 1; k++) begin
            step();
            drive_start(unit, poke && (k == 50 || k == 207));
            get(unit, sc, sd, sl, bz, dn, sel);
            if (k == 1) begin
                chk("busy_cycle1", 32'(bz), 32'd1);
                chk("select_cycle1", 32'(sel), 32'd0);
            end
            if (sc && !prev_sc) begin
                got.push_back(sd);
                if (first_rise < 0) first_rise = k;
            end
            if (sc) hi_run++;
            else if (hi_run > 0) begin
                if (hi_run != div) bad_hi++;
                hi_run = 0;
            end
            if (sl) begin
                if (latch_first < 0) latch_first = k;
                latch_n++;
                if (sc || sd) latch_bad++;
            end
            if (dn) begin
                done_n++;
                done_cyc = k;
            end
            if (k <= f && !bz) busy_gap++;
            prev_sc = sc;
        end

        chk("bit_count", 32'(got.size()), 32'd48);
        for (int d = 0; d < c_digits; d++) begin
            exp_byte = {dp[d] & c_dp_en, pat[d]};
            obs_byte = 8'hxx;
            if (got.size() >= (d + 1) * 8)
                for (int b = 0; b < 8; b++) obs_byte[7 - b] = got[d * 8 + b];
            chk($sformatf("byte_digit%0d", d), 32'(obs_byte), 32'(exp_byte));
        end
        chk("first_rise_cycle", 32'(first_rise), 32'(3 + div));
        chk("latch_first_cycle", 32'(latch_first), 32'(f - div));
        chk("latch_length", 32'(latch_n), 32'(div));
        chk("latch_clk_data_low", 32'(latch_bad), 32'd0);
        chk("done_cycle", 32'(done_cyc), 32'(f));
        chk("done_pulses", 32'(done_n), 32'd1);
        chk("busy_gaps", 32'(busy_gap), 32'd0);
        chk("busy_after_frame", 32'(bz), 32'd0);
        chk("sclk_high_len", 32'(bad_hi), 32'd0);
        chk("select_holds_last", 32'(sel), 32'(c_digits - 1));
    endtask

    initial begin
        logic       sc, sd, sl, bz, dn;
        logic [2:0] sel;
        int         edges, busy_seen, latch_seen;

        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; dp = '0;
        for (int i = 0; i < 8; i++) pat[i] = '0;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) step();
        chk("reset_outputs_dut1", 32'({sel1, sd1, sc1, sl1, bz1, dn1}), 32'd0);
        chk("reset_outputs_dut2", 32'({sel2, sd2, sc2, sl2, bz2, dn2}), 32'd0);

        // Idle after release: no serial clock activity, never busy
        rst_n = 1'b1;
        edges = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sc1 || sc2) edges++;
            if (bz1 || bz2) busy_seen++;
        end
        chk("idle_no_sclk", 32'(edges), 32'd0);
        chk("idle_not_busy", 32'(busy_seen), 32'd0);

        // Frame with ignored start pulses at 50 and 207, then back-to-back frame at 208
        run_frame(1, 2, 1'b1);
        run_frame(1, 2, 1'b0);

        // Reset in the middle of shifting
        for (int i = 0; i < 8; i++) pat[i] = 7'($urandom);
        start1 = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            start1 = 1'b0;
        end
        rst_n = 1'b0;
        step();
        get(1, sc, sd, sl, bz, dn, sel);
        chk("midreset_outputs", 32'({sel, sd, sc, sl, bz, dn}), 32'd0);
        rst_n = 1'b1;
        latch_seen = 0; busy_seen = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (sl1) latch_seen++;
            if (bz1) busy_seen++;
        end
        chk("midreset_no_latch", 32'(latch_seen), 32'd0);
        chk("midreset_stays_idle", 32'(busy_seen), 32'd0);
        run_frame(1, 2, 1'b0);

        // Fastest divider
        run_frame(2, 1, 1'b0);
        run_frame(2, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/segment_shift_tx.md
# segment_shift_tx

Serial transmitter feeding the clock's external 7-segment shift-register chain. Steps `o_segment_select` through digit indices 0–5 and waits out the registered BCD mux plus the combinational 7-segment decode. It then captures each 7-bit segment pattern (plus an optional decimal point) and shifts it out MSB-first on a data/clock pair. A single latch pulse ends each frame.

## Interface
- `CLK_DIV`, default 2: `i_clk` cycles per serial-clock half period; minimum 1.
- `NUM_DIGITS`, default 6: digits per frame; select counts 0..NUM_DIGITS-1.
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  synchronous, active-low reset; `i_clk` is the clock.
- `i_start`  in  1  frame request; sampled only in IDLE.
- `i_led_out`  in  7  segment pattern returned by the digit mux/decoder.
- `i_dp`  in  6  per-digit decimal point; present only with `SEGMENT_TX_DP_EN`.
- `o_segment_select`  out  3  digit index driven to the mux.
- `o_serial_data`  out  1  shift-register data.
- `o_serial_clk`  out  1  shift clock; the chain samples on the rising edge.
- `o_serial_latch`  out  1  storage-register latch; active high.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Reset values:
  - All outputs are 0, including `o_segment_select`.
  - State is IDLE; all counters are 0.
- States:
  - IDLE: `i_start`=1 → SELECT with digit=0.
  - SELECT: lasts exactly 2 cycles with `o_segment_select`=digit. On the last SELECT cycle, load shift_reg = {dp_bit, `i_led_out`}, then go to SHIFT.
  - SHIFT: 8 bits, bit 7 first. Each bit is CLK_DIV cycles with `o_serial_clk`=0, then CLK_DIV cycles with `o_serial_clk`=1.
    - `o_serial_data` is updated only at the start of the low phase.
    - After bit 0: if digit < NUM_DIGITS-1, increment digit and go to SELECT; otherwise go to LATCH.
  - LATCH: `o_serial_latch`=1 for CLK_DIV cycles; `o_serial_clk`=0 and `o_serial_data`=0.
  - DONE: `o_done`=1 for one cycle, then IDLE.
- `o_busy`=1 in every state except IDLE.
- Digit 0 (seconds LSB) is shifted first and therefore ends at the far end of the chain.
- `i_start` is ignored outside IDLE, including in DONE. No request is queued.
- `o_segment_select` holds its last value (NUM_DIGITS-1) after the frame. It returns to 0 only on the next start or on reset.
- `o_serial_data` and `o_serial_clk` return to 0 in IDLE.
- Reset mid-frame: on the next edge, all outputs and state return to reset values. No latch pulse is emitted.
- Bit and divider counters are sized with `$clog2`. Wrap-around is never relied on; counters are reloaded explicitly at each phase end.

## Timing
- `i_start` sampled at cycle 0 → `o_busy`=1 and select=0 from cycle 1.
- The mux registers on the cycle-1 edge; decoded segments are valid during cycle 2; capture happens at the end of cycle 2.
- Per digit: 2 + 16·CLK_DIV cycles. Frame: NUM_DIGITS·(2 + 16·CLK_DIV) + CLK_DIV + 1 cycles.
- CLK_DIV=2 frame:
  - SHIFT for digit 0 occupies cycles 3–34.
  - First `o_serial_clk` rise at cycle 5.
  - LATCH occupies cycles 205–206.
  - `o_done` at cycle 207.
  - `o_busy` low from cycle 208.
  - Earliest next start is sampled at cycle 208.

## Configuration
- `SEGMENT_TX_DP_EN` defined:
  - Port `i_dp` exists.
  - Bit 7 of each shifted byte = `i_dp[digit]`, sampled at the capture cycle.
- `SEGMENT_TX_DP_EN` undefined:
  - No `i_dp` port.
  - Bit 7 is always 0.
  - All timing is unchanged.

## Structure
- Package `display_pkg` holds:
  - State encoding: IDLE, SELECT, SHIFT, LATCH, DONE.
  - `NUM_DIGITS_DEFAULT`=6.
  - `SEG_BITS`=8.
  - `SELECT_WAIT`=2.
  - `BLANK_BCD`=4'hA, shared with the mux.
- Sub-module `serial_tick_gen`: CLK_DIV divider emitting a one-cycle phase-end tick. It is restartable via a clear input and is used by SHIFT and LATCH.

## Test plan
- Reset: hold `i_reset_n`=0 for 3 cycles → all outputs 0, `o_busy`=0; no `o_serial_clk` edges for 20 cycles after release without `i_start`.
- Single frame, CLK_DIV=2: model returns `i_led_out`=7'h10+select two cycles after the select change.
  - Expect 48 rising-edge samples = {0,7'h10},{0,7'h11},…,{0,7'h15}.
  - Expect latch high on cycles 205–206 and `o_done` at 207.
- Start while busy: pulse `i_start` at cycles 50 and 207 → ignored. A pulse at 208 starts a second frame, with `o_busy` rising at 209.
- Reset mid-shift: assert reset at cycle 100 → all outputs 0 at 101; no latch pulse; a later start gives a full, correct frame.
- CLK_DIV=1: frame = 6·18+2 = 110 cycles, `o_done` at cycle 110; each serial-clock high/low phase is exactly 1 cycle.
- `SEGMENT_TX_DP_EN` with `i_dp`=6'b000101: bit 7 is 1 for digits 0 and 2 only. With the macro undefined, bit 7 is always 0.
